// File: rtl/sap_program_counter_stack.sv
// sap_program_counter_stack
// SAP program counter with jump load, CALL/RET return-address stack,
// stack status flags and a tri-state W-bus driver (PC) plus an
// always-driven copy (PcQ). All state changes happen on the falling edge
// of Clk; ClrN is an asynchronous active-low clear.
// Optional build macro: SAP_PC_STACK_ERR_EN adds a sticky StkErr output
// that records an overflowing Call or an underflowing Ret.
module sap_program_counter_stack #(
  parameter int              WIDTH   = 4,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             ClrN,
  input  logic             Cp,
  input  logic             Lp,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Ep,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PcQ,
  output logic             StkEmpty,
  output logic             StkFull
`ifdef SAP_PC_STACK_ERR_EN
  ,
  output logic             StkErr
`endif
);

  // sp counts occupied entries, so it needs to represent 0..DEPTH
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [SPW-1:0]   sp_reg;
  logic [SPW-1:0]   sp_next;
  logic             push_en;
  logic             is_empty;
  logic             is_full;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  top_idx;
  logic [SPW-1:0]   sp_dec;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  assign is_empty = (sp_reg == '0);
  assign is_full  = (sp_reg == SPW'(DEPTH));
  assign sp_dec   = sp_reg - 1'b1;
  // push writes slot sp, pop reads slot sp-1; both only used when in range
  assign push_idx = sp_reg[IDXW-1:0];
  assign top_idx  = sp_dec[IDXW-1:0];

  // Next-state selection with fixed priority Ret > Call > Lp > Cp
  always_comb begin
    pc_next = pc_reg;
    sp_next = sp_reg;
    push_en = 1'b0;
    if (Ret) begin
      // an empty-stack Ret still claims the cycle, masking lower requests
      if (!is_empty) begin
        pc_next = stack_mem[top_idx];
        sp_next = sp_dec;
      end
    end else if (Call) begin
      // the jump happens even when the push has to be dropped
      pc_next = Din;
      if (!is_full) begin
        push_en = 1'b1;
        sp_next = sp_reg + 1'b1;
      end
    end else if (Lp) begin
      pc_next = Din;
    end else if (Cp) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  // PC and stack pointer registers, cleared asynchronously
  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      pc_reg <= RST_VAL;
      sp_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      sp_reg <= sp_next;
    end
  end

  // Return-address storage; contents are left alone by reset, and a push
  // coinciding with an active clear is discarded
  always_ff @(negedge Clk) begin
    if (ClrN && push_en) begin
      stack_mem[push_idx] <= pc_reg;
    end
  end

`ifdef SAP_PC_STACK_ERR_EN
  logic err_evt;
  logic err_reg;

  // error only when the offending request was the one that won priority
  assign err_evt = Ret ? is_empty : (Call & is_full);

  // Sticky overflow/underflow flag, cleared only by ClrN
  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      err_reg <= 1'b0;
    end else if (err_evt) begin
      err_reg <= 1'b1;
    end
  end

  assign StkErr = err_reg;
`endif

  assign PcQ      = pc_reg;
  assign PC       = Ep ? pc_reg : 'z;
  assign StkEmpty = is_empty;
  assign StkFull  = is_full;

endmodule

// File: tb/tb_sap_program_counter_stack.sv
// Bench for sap_program_counter_stack (WIDTH=4, DEPTH=2, RST_VAL=0).
// A queue-based reference model tracks PC, the return stack and the error
// flag; one process compares the DUT against it every cycle, and the
// directed stimulus also checks hand-computed literal values.
module tb_sap_program_counter_stack;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         cp = 1'b0;
  logic         lp = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic         ep = 1'b0;
  logic [W-1:0] din = '0;
  wire  [W-1:0] pc_bus;
  logic [W-1:0] pcq;
  logic         stk_empty;
  logic         stk_full;
`ifdef SAP_PC_STACK_ERR_EN
  logic         stk_err;
`endif

  // the bench parks a known pattern on the bus whenever the DUT should be off it
  logic [W-1:0] park_val = 4'b1010;
  assign pc_bus = ep ? 'z : park_val;

  sap_program_counter_stack #(.WIDTH(W), .DEPTH(D), .RST_VAL(4'd0)) dut (
    .Clk(clk), .ClrN(clr_n), .Cp(cp), .Lp(lp), .Call(call), .Ret(ret),
    .Ep(ep), .Din(din), .PC(pc_bus), .PcQ(pcq),
    .StkEmpty(stk_empty), .StkFull(stk_full)
`ifdef SAP_PC_STACK_ERR_EN
    , .StkErr(stk_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference model
  int m_pc = 0;
  int m_stack[$];
  bit m_err = 0;

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 0;
  endtask

  always @(negedge clr_n) model_reset();

  always @(negedge clk) begin
    if (!clr_n) model_reset();
    else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_err = 1;
    end else if (call) begin
      if (m_stack.size() < D) m_stack.push_back(m_pc);
      else m_err = 1;
      m_pc = int'(din);
    end else if (lp) m_pc = int'(din);
    else if (cp) m_pc = (m_pc + 1) % (1 << W);
  end

  // per-cycle comparison against the model, well clear of the falling edge
  always @(posedge clk) begin
    #3;
    if (check_en) begin
      chk("m_pcq", int'(pcq), m_pc);
      chk("m_empty", int'(stk_empty), int'(m_stack.size() == 0));
      chk("m_full", int'(stk_full), int'(m_stack.size() == D));
      if (ep) chk("m_bus", int'(pc_bus), m_pc);
      else    chk("m_bus_hiz", int'(pc_bus), int'(park_val));
`ifdef SAP_PC_STACK_ERR_EN
      chk("m_err", int'(stk_err), int'(m_err));
`endif
    end
  end

  // one transaction: drive after the rising edge, check after the falling edge
  task automatic cyc(input logic r, input logic c, input logic l, input logic p,
                     input logic [W-1:0] d, input int exp_pc, input string name);
    @(posedge clk);
    #1;
    ret = r; call = c; lp = l; cp = p; din = d;
    @(negedge clk);
    #1;
    $display("%s: ret=%0b call=%0b lp=%0b cp=%0b din=%0d ep=%0b -> pcq=%0d empty=%0b full=%0b",
             name, r, c, l, p, d, ep, pcq, stk_empty, stk_full);
    chk(name, int'(pcq), exp_pc);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    ret = 0; call = 0; lp = 0; cp = 0;
    clr_n = 0;
    #1;
    chk("rst_pcq", int'(pcq), 0);
    chk("rst_empty", int'(stk_empty), 1);
    chk("rst_full", int'(stk_full), 0);
`ifdef SAP_PC_STACK_ERR_EN
    chk("rst_err", int'(stk_err), 0);
`endif
    @(posedge clk);
    #1;
    clr_n = 1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    // initial reset held across a couple of falling edges
    repeat (2) @(negedge clk);
    #1;
    chk("init_pcq", int'(pcq), 0);
    chk("init_empty", int'(stk_empty), 1);
    chk("init_full", int'(stk_full), 0);
    @(posedge clk);
    #1;
    clr_n = 1;
    check_en = 1;

    // count 0 -> 15 -> 0 -> 1, bus disabled then enabled
    for (int i = 0; i < 17; i++) begin
      ep = (i >= 8);
      cyc(0, 0, 0, 1, 4'd0, (i + 1) % 16, "count");
    end
    // continue to 9
    for (int i = 2; i <= 9; i++) cyc(0, 0, 0, 1, 4'd0, i, "count9");

    // asynchronous clear between edges
    @(posedge clk);
    #1;
    cp = 0;
    chk("pre_async", int'(pcq), 9);
    clr_n = 0;
    #1;
    chk("async_clr", int'(pcq), 0);
    $display("async_clr: pcq=%0d", pcq);
    @(posedge clk);
    #1;
    clr_n = 1;

    // count to 3, then load beats count
    cyc(0, 0, 0, 1, 4'd0, 1, "cnt");
    cyc(0, 0, 0, 1, 4'd0, 2, "cnt");
    cyc(0, 0, 0, 1, 4'd0, 3, "cnt");
    cyc(0, 0, 1, 1, 4'd12, 12, "load_prio");

    // call/ret nesting including overflow and underflow
    cyc(0, 0, 1, 0, 4'd5, 5, "load5");
    cyc(0, 1, 0, 0, 4'd10, 10, "call10");
    chk("call10_empty", int'(stk_empty), 0);
    cyc(0, 1, 0, 0, 4'd14, 14, "call14");
    chk("call14_full", int'(stk_full), 1);
    cyc(0, 1, 0, 0, 4'd7, 7, "call_ovf");
    chk("ovf_full", int'(stk_full), 1);
`ifdef SAP_PC_STACK_ERR_EN
    chk("ovf_err", int'(stk_err), 1);
`endif
    cyc(1, 0, 0, 0, 4'd0, 10, "ret1");
    chk("ret1_full", int'(stk_full), 0);
    cyc(1, 0, 0, 0, 4'd0, 5, "ret2");
    chk("ret2_empty", int'(stk_empty), 1);
    cyc(1, 0, 0, 1, 4'd0, 5, "ret_unf");
`ifdef SAP_PC_STACK_ERR_EN
    chk("unf_err", int'(stk_err), 1);
`endif
    pulse_reset();

    // simultaneous Ret+Call+Cp pops and does not push
    cyc(0, 0, 1, 0, 4'd6, 6, "load6");
    cyc(0, 1, 0, 0, 4'd2, 2, "call2");
    cyc(1, 1, 0, 1, 4'd9, 6, "ret_call_cp");
    chk("rcc_empty", int'(stk_empty), 1);
    chk("rcc_full", int'(stk_full), 0);
    cyc(1, 0, 0, 0, 4'd0, 6, "ret_empty");

    // wrap from all-ones, then idle hold
    cyc(0, 0, 1, 0, 4'd15, 15, "load15");
    cyc(0, 0, 0, 1, 4'd0, 0, "wrap");
    ep = 0;
    cyc(0, 0, 0, 0, 4'd3, 0, "idle");
    cyc(0, 0, 0, 0, 4'd3, 0, "idle");

    @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
